// File: rtl/video_pkg.sv
// Shared video types: 12-bit coordinates, raster phase enum, 1280x720@60 default timing.
// Latency: none (declarations only). Backpressure: none.
package video_pkg;

    typedef logic [11:0] coord_t;

    localparam int COORD_RANGE = 4096;

    localparam int DEF_H_ACTIVE = 1280;
    localparam int DEF_H_FP     = 110;
    localparam int DEF_H_SYNC   = 40;
    localparam int DEF_H_BP     = 220;
    localparam int DEF_V_ACTIVE = 720;
    localparam int DEF_V_FP     = 5;
    localparam int DEF_V_SYNC   = 5;
    localparam int DEF_V_BP     = 20;
    localparam bit DEF_HS_POL   = 1'b1;
    localparam bit DEF_VS_POL   = 1'b1;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FRONT  = 2'd1,
        SYNC   = 2'd2,
        BACK   = 2'd3
    } vtg_phase_t;

    function automatic int vtg_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Raster timing bundle between video_timing_gen (master) and its consumers (slave).
// Latency: none (wiring only). Backpressure: en low freezes the master.
interface video_timing_gen_if;
    import video_pkg::*;

    logic   en;
    coord_t pixel_cnt;
    coord_t line_cnt;
    logic   video_on;
    logic   hsync;
    logic   vsync;
    logic   frame_start;

`ifdef VTG_FRAME_CNT_EN
    logic [15:0] frame_cnt;

    modport master (
        input  en,
        output pixel_cnt, line_cnt, video_on, hsync, vsync, frame_start, frame_cnt
    );
    modport slave (
        output en,
        input  pixel_cnt, line_cnt, video_on, hsync, vsync, frame_start, frame_cnt
    );
`else
    modport master (
        input  en,
        output pixel_cnt, line_cnt, video_on, hsync, vsync, frame_start
    );
    modport slave (
        output en,
        input  pixel_cnt, line_cnt, video_on, hsync, vsync, frame_start
    );
`endif

endinterface

// File: rtl/vtg_axis_cnt.sv
// One raster axis: position counter plus ACTIVE/FRONT/SYNC/BACK phase FSM, both advanced by tick.
// Latency: cnt/phase update on the ticking edge. Backpressure: tick low holds all state.
module vtg_axis_cnt
    import video_pkg::coord_t;
    import video_pkg::vtg_phase_t;
#(
    parameter int ACTIVE = 1280,
    parameter int FP     = 110,
    parameter int SYNC   = 40,
    parameter int BP     = 220
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    output coord_t     cnt,
    output vtg_phase_t phase,
    output vtg_phase_t phase_nxt,
    output logic       wrap
);

    localparam int     TOTAL      = ACTIVE + FP + SYNC + BP;
    localparam coord_t LAST       = coord_t'(TOTAL - 1);
    localparam coord_t FP_START   = coord_t'(ACTIVE);
    localparam coord_t SYNC_START = coord_t'(ACTIVE + FP);
    localparam coord_t BP_START   = coord_t'(ACTIVE + FP + SYNC);

    coord_t cnt_nxt;

    assign wrap = tick && (cnt == LAST);

    always_comb begin
        cnt_nxt = cnt;
        if (tick) begin
            cnt_nxt = wrap ? '0 : cnt + coord_t'(1);
        end
    end

    // Phase is keyed on the next count so it stays aligned with cnt after the edge.
    always_comb begin
        phase_nxt = phase;
        case (phase)
            video_pkg::ACTIVE: if (cnt_nxt == FP_START)   phase_nxt = video_pkg::FRONT;
            video_pkg::FRONT:  if (cnt_nxt == SYNC_START) phase_nxt = video_pkg::SYNC;
            video_pkg::SYNC:   if (cnt_nxt == BP_START)   phase_nxt = video_pkg::BACK;
            video_pkg::BACK:   if (cnt_nxt == '0)         phase_nxt = video_pkg::ACTIVE;
            default:                                      phase_nxt = video_pkg::BACK;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= LAST;
            phase <= video_pkg::BACK;
        end else begin
            cnt   <= cnt_nxt;
            phase <= phase_nxt;
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator (pixel/line counts, video_on, syncs, frame_start); VTG_FRAME_CNT_EN adds frame_cnt.
// Latency: all outputs registered, zero skew vs counts. Backpressure: en low holds every flop.
module video_timing_gen
    import video_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = DEF_HS_POL,
    parameter bit VS_POL   = DEF_VS_POL
) (
    input  logic               rfr_clk,
    input  logic               reset,
    video_timing_gen_if.master vtg
);

    localparam int H_TOTAL = vtg_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = vtg_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (H_TOTAL > COORD_RANGE) begin : g_h_range
        $error("video_timing_gen: H_TOTAL exceeds 4096");
    end
    if (V_TOTAL > COORD_RANGE) begin : g_v_range
        $error("video_timing_gen: V_TOTAL exceeds 4096");
    end

    logic       h_wrap;
    logic       v_wrap;
    logic       v_tick;
    vtg_phase_t h_phase;
    vtg_phase_t h_phase_nxt;
    vtg_phase_t v_phase;
    vtg_phase_t v_phase_nxt;

    assign v_tick = vtg.en & h_wrap;

    vtg_axis_cnt #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h_axis (
        .clk       (rfr_clk),
        .reset     (reset),
        .tick      (vtg.en),
        .cnt       (vtg.pixel_cnt),
        .phase     (h_phase),
        .phase_nxt (h_phase_nxt),
        .wrap      (h_wrap)
    );

    vtg_axis_cnt #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v_axis (
        .clk       (rfr_clk),
        .reset     (reset),
        .tick      (v_tick),
        .cnt       (vtg.line_cnt),
        .phase     (v_phase),
        .phase_nxt (v_phase_nxt),
        .wrap      (v_wrap)
    );

    // Decode from next-phase so the registered flags land with the counts.
    always_ff @(posedge rfr_clk or posedge reset) begin
        if (reset) begin
            vtg.video_on    <= 1'b0;
            vtg.hsync       <= ~HS_POL;
            vtg.vsync       <= ~VS_POL;
            vtg.frame_start <= 1'b0;
        end else if (vtg.en) begin
            vtg.video_on    <= (h_phase_nxt == ACTIVE) && (v_phase_nxt == ACTIVE);
            vtg.hsync       <= (h_phase_nxt == SYNC) ? HS_POL : ~HS_POL;
            vtg.vsync       <= (v_phase_nxt == SYNC) ? VS_POL : ~VS_POL;
            vtg.frame_start <= v_wrap;
        end
    end

`ifdef VTG_FRAME_CNT_EN
    always_ff @(posedge rfr_clk or posedge reset) begin
        if (reset) begin
            vtg.frame_cnt <= '0;
        end else if (v_wrap) begin
            vtg.frame_cnt <= vtg.frame_cnt + 16'd1;
        end
    end
`endif

    a_flags_match_phase: assert property (@(posedge rfr_clk) disable iff (reset)
        (vtg.video_on == ((h_phase == ACTIVE) && (v_phase == ACTIVE))) &&
        (vtg.hsync == ((h_phase == SYNC) ? HS_POL : ~HS_POL)) &&
        (vtg.vsync == ((v_phase == SYNC) ? VS_POL : ~VS_POL)));

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: default 720p instance plus a tiny-raster instance, against a position model.
module tb_video_timing_gen;

    localparam int DHA = 1280, DHF = 110, DHS = 40, DHB = 220;
    localparam int DVA = 720,  DVF = 5,   DVS = 5,  DVB = 20;
    localparam int DHT = DHA + DHF + DHS + DHB;
    localparam int DVT = DVA + DVF + DVS + DVB;
    localparam int SHA = 4, SHF = 1, SHS = 1, SHB = 1;
    localparam int SVA = 2, SVF = 1, SVS = 1, SVB = 1;
    localparam int SHT = SHA + SHF + SHS + SHB;
    localparam int SVT = SVA + SVF + SVS + SVB;

    logic clk = 1'b0;
    logic d_rst;
    logic s_rst;
    int   checks = 0;
    int   passed = 0;

    int d_px, d_ln;
    int s_px, s_ln, s_fc;

    video_timing_gen_if vif ();
    video_timing_gen_if sif ();

    video_timing_gen u_dut (
        .rfr_clk (clk),
        .reset   (d_rst),
        .vtg     (vif)
    );

    video_timing_gen #(
        .H_ACTIVE (SHA), .H_FP (SHF), .H_SYNC (SHS), .H_BP (SHB),
        .V_ACTIVE (SVA), .V_FP (SVF), .V_SYNC (SVS), .V_BP (SVB),
        .HS_POL   (1'b0), .VS_POL (1'b1)
    ) u_small (
        .rfr_clk (clk),
        .reset   (s_rst),
        .vtg     (sif)
    );

    always #5 clk = ~clk;

    function automatic logic [27:0] ref_out(input int px, input int ln, input int ha, input int hf,
                                            input int hs, input int va, input int vf, input int vs,
                                            input logic hpol, input logic vpol);
        logic vo, hsy, vsy, fs;
        vo  = (px < ha) && (ln < va);
        hsy = (px >= ha + hf && px < ha + hf + hs) ? hpol : ~hpol;
        vsy = (ln >= va + vf && ln < va + vf + vs) ? vpol : ~vpol;
        fs  = (px == 0) && (ln == 0);
        return {12'(px), 12'(ln), vo, hsy, vsy, fs};
    endfunction

    function automatic logic [27:0] d_ref();
        return ref_out(d_px, d_ln, DHA, DHF, DHS, DVA, DVF, DVS, 1'b1, 1'b1);
    endfunction

    function automatic logic [27:0] s_ref();
        return ref_out(s_px, s_ln, SHA, SHF, SHS, SVA, SVF, SVS, 1'b0, 1'b1);
    endfunction

    function automatic logic [27:0] d_got();
        return {vif.pixel_cnt, vif.line_cnt, vif.video_on, vif.hsync, vif.vsync, vif.frame_start};
    endfunction

    function automatic logic [27:0] s_got();
        return {sif.pixel_cnt, sif.line_cnt, sif.video_on, sif.hsync, sif.vsync, sif.frame_start};
    endfunction

    // Advance both position models on a clock edge, then settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        if (d_rst) begin
            d_px = DHT - 1; d_ln = DVT - 1;
        end else if (vif.en) begin
            d_px = (d_px + 1) % DHT;
            if (d_px == 0) d_ln = (d_ln + 1) % DVT;
        end
        if (s_rst) begin
            s_px = SHT - 1; s_ln = SVT - 1; s_fc = 0;
        end else if (sif.en) begin
            s_px = (s_px + 1) % SHT;
            if (s_px == 0) s_ln = (s_ln + 1) % SVT;
            if (s_px == 0 && s_ln == 0) s_fc = (s_fc + 1) % 65536;
        end
        #1;
    endtask

    task automatic test_reset();
        logic [27:0] exp;
        vif.en = 1'b1;
        d_rst  = 1'b1;
        tick();
        tick();
        exp = {12'd1649, 12'd749, 1'b0, 1'b0, 1'b0, 1'b0};
        checks++;
        if (d_got() !== exp) $display("FAIL reset_state got=%h exp=%h", d_got(), exp);
        else passed++;
        d_rst = 1'b0;
        tick();
        exp = {12'd0, 12'd0, 1'b1, 1'b0, 1'b0, 1'b1};
        checks++;
        if (d_got() !== exp) $display("FAIL first_edge got=%h exp=%h", d_got(), exp);
        else passed++;
        tick();
        exp = {12'd1, 12'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        checks++;
        if (d_got() !== exp) $display("FAIL second_edge got=%h exp=%h", d_got(), exp);
        else passed++;
    endtask

    task automatic test_one_line();
        int   hs_cnt = 0;
        int   hs_first = -1;
        int   vo_fall = -1;
        logic prev_vo;
        prev_vo = vif.video_on;
        for (int i = 0; i < 2000 && !(d_px == 0 && d_ln == 1); i++) begin
            tick();
            checks++;
            if (d_got() !== d_ref()) $display("FAIL line_cycle got=%h exp=%h", d_got(), d_ref());
            else passed++;
            if (vif.hsync) begin
                if (hs_first < 0) hs_first = int'(vif.pixel_cnt);
                hs_cnt++;
            end
            if (prev_vo && !vif.video_on && vo_fall < 0) vo_fall = int'(vif.pixel_cnt);
            prev_vo = vif.video_on;
        end
        checks++;
        if (hs_cnt !== 40) $display("FAIL hsync_width got=%0d exp=40", hs_cnt);
        else passed++;
        checks++;
        if (hs_first !== 1390) $display("FAIL hsync_start got=%0d exp=1390", hs_first);
        else passed++;
        checks++;
        if (vo_fall !== 1280) $display("FAIL video_on_fall got=%0d exp=1280", vo_fall);
        else passed++;
        checks++;
        if ({vif.pixel_cnt, vif.line_cnt} !== {12'd0, 12'd1})
            $display("FAIL line_wrap got=%0d,%0d exp=0,1", vif.pixel_cnt, vif.line_cnt);
        else passed++;
    endtask

    task automatic test_reset_mid();
        logic [27:0] exp;
        vif.en = 1'b1;
        for (int i = 0; i < 3000 && !(d_px == 640 && d_ln == 1); i++) begin
            tick();
            checks++;
            if (d_got() !== d_ref()) $display("FAIL mid_run got=%h exp=%h", d_got(), d_ref());
            else passed++;
        end
        #2;
        d_rst = 1'b1;
        d_px = DHT - 1; d_ln = DVT - 1;
        #1;
        exp = {12'd1649, 12'd749, 1'b0, 1'b0, 1'b0, 1'b0};
        checks++;
        if (d_got() !== exp) $display("FAIL async_reset got=%h exp=%h", d_got(), exp);
        else passed++;
        tick();
        d_rst = 1'b0;
        tick();
        exp = {12'd0, 12'd0, 1'b1, 1'b0, 1'b0, 1'b1};
        checks++;
        if (d_got() !== exp) $display("FAIL restart_after_reset got=%h exp=%h", d_got(), exp);
        else passed++;
    endtask

    task automatic test_en_hold();
        logic [27:0] exp;
        vif.en = 1'b0;
        d_rst  = 1'b1;
        tick();
        d_rst = 1'b0;
        exp = {12'd1649, 12'd749, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (d_got() !== exp) $display("FAIL hold_at_end got=%h exp=%h", d_got(), exp);
            else passed++;
        end
        vif.en = 1'b1;
        tick();
        exp = {12'd0, 12'd0, 1'b1, 1'b0, 1'b0, 1'b1};
        checks++;
        if (d_got() !== exp) $display("FAIL resume_origin got=%h exp=%h", d_got(), exp);
        else passed++;
        vif.en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (d_got() !== exp) $display("FAIL hold_frame_start got=%h exp=%h", d_got(), exp);
            else passed++;
        end
        vif.en = 1'b1;
        tick();
        exp = {12'd1, 12'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        checks++;
        if (d_got() !== exp) $display("FAIL single_pulse got=%h exp=%h", d_got(), exp);
        else passed++;
    endtask

    task automatic test_random_en();
        for (int i = 0; i < 2000; i++) begin
            vif.en = ($urandom_range(0, 3) != 0);
            tick();
            checks++;
            if (d_got() !== d_ref()) $display("FAIL random_en got=%h exp=%h", d_got(), d_ref());
            else passed++;
        end
        vif.en = 1'b0;
    endtask

    task automatic test_small_frames();
        int last_fs = -1;
        int nfs = 0;
        int vs_cnt = 0;
        int hs_lo = 0;
        sif.en = 1'b1;
        s_rst  = 1'b1;
        tick();
        s_rst = 1'b0;
        for (int cyc = 0; cyc < 3 * SHT * SVT; cyc++) begin
            tick();
            checks++;
            if (s_got() !== s_ref()) $display("FAIL small_cycle got=%h exp=%h", s_got(), s_ref());
            else passed++;
            if (sif.vsync) vs_cnt++;
            if (!sif.hsync) hs_lo++;
            if (sif.frame_start) begin
                nfs++;
                if (last_fs >= 0) begin
                    checks++;
                    if (cyc - last_fs !== SHT * SVT)
                        $display("FAIL frame_period got=%0d exp=%0d", cyc - last_fs, SHT * SVT);
                    else passed++;
                end
                last_fs = cyc;
`ifdef VTG_FRAME_CNT_EN
                checks++;
                if (sif.frame_cnt !== 16'(nfs)) $display("FAIL frame_cnt got=%0d exp=%0d", sif.frame_cnt, nfs);
                else passed++;
`endif
            end
        end
        checks++;
        if (nfs !== 3) $display("FAIL small_frame_count got=%0d exp=3", nfs);
        else passed++;
        checks++;
        if (vs_cnt !== 3 * SVS * SHT) $display("FAIL small_vsync_cycles got=%0d exp=%0d", vs_cnt, 3 * SVS * SHT);
        else passed++;
        checks++;
        if (hs_lo !== 3 * SVT * SHS) $display("FAIL small_hsync_low got=%0d exp=%0d", hs_lo, 3 * SVT * SHS);
        else passed++;
    endtask

    task automatic test_small_random();
        for (int i = 0; i < 400; i++) begin
            sif.en = ($urandom_range(0, 2) != 0);
            tick();
            checks++;
            if (s_got() !== s_ref()) $display("FAIL small_random got=%h exp=%h", s_got(), s_ref());
            else passed++;
`ifdef VTG_FRAME_CNT_EN
            checks++;
            if (sif.frame_cnt !== 16'(s_fc)) $display("FAIL small_random_fc got=%0d exp=%0d", sif.frame_cnt, s_fc);
            else passed++;
`endif
        end
        sif.en = 1'b0;
    endtask

    initial begin
        d_rst  = 1'b1;
        s_rst  = 1'b1;
        vif.en = 1'b0;
        sif.en = 1'b0;
        d_px = DHT - 1; d_ln = DVT - 1;
        s_px = SHT - 1; s_ln = SVT - 1; s_fc = 0;
        test_reset();
        test_one_line();
        test_reset_mid();
        test_en_hold();
        test_random_en();
        vif.en = 1'b0;
        test_small_frames();
        test_small_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
